// File: rtl/rf_wb_sched_pkg.sv
// Shared CPU definitions: register-file geometry, the zero register and
// the write-back source identifiers used by the write-back scheduler.
package rf_wb_sched_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [0:0] {
      SRC_ALU = 1'b0,
      SRC_LSU = 1'b1
   } wb_src_e;

   function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
      return (addr == REG_ZERO);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the source favoured when
// both request and always moves to the source that lost the last grant.
module rr_arb2
   import rf_wb_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   wb_src_e rr_r;

   // Grant the lone requester, or the pointer's choice on contention
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11: begin
            if (rr_r == SRC_ALU) gnt = 2'b01;
            else                 gnt = 2'b10;
         end
         default: gnt = 2'b00;
      endcase
   end

   // Pointer register: after any grant, favour the other source next time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rr_r <= SRC_ALU;
      else if (gnt[0])  rr_r <= SRC_LSU;
      else if (gnt[1])  rr_r <= SRC_ALU;
      else              rr_r <= rr_r;
   end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and hazard scoreboard: shares the register-file write
// port between the ALU and load/multi-cycle unit and stalls issue on hazards.
module rf_wb_sched
   import rf_wb_sched_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = XLEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_src0_valid,
   input  logic [ADDR_W-1:0] i_src0_rd,
   input  logic [DATA_W-1:0] i_src0_data,
   output logic              o_src0_ready,
   input  logic              i_src1_valid,
   input  logic [ADDR_W-1:0] i_src1_rd,
   input  logic [DATA_W-1:0] i_src1_data,
   output logic              o_src1_ready,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   input  logic              i_issue_valid,
   input  logic [ADDR_W-1:0] i_issue_rs1,
   input  logic [ADDR_W-1:0] i_issue_rs2,
   input  logic [ADDR_W-1:0] i_issue_rd,
   input  logic              i_issue_multi,
   output logic              o_issue_stall,
   output logic              o_wb_err
);

   localparam int NREG = 2 ** ADDR_W;

   logic [1:0]        req_s;
   logic [1:0]        gnt_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic [DATA_W-1:0] wr_data_s;
   logic [NREG-1:0]   busy_r;
   logic [NREG-1:0]   clr_vec_s;
   logic [NREG-1:0]   set_vec_s;
   logic [NREG-1:0]   eff_s;
   logic              stall_s;
   logic              issue_set_s;
   logic              wb_err_r;

   // Requests are masked during reset so no grant or write can leak out
   assign req_s = {i_src1_valid, i_src0_valid} & {2{rst_n}};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_s),
      .gnt   (gnt_s)
   );

   // Write-port mux driven by the granted source
   always_comb begin
      wr_addr_s = i_src0_rd;
      wr_data_s = i_src0_data;
      if (gnt_s[1]) begin
         wr_addr_s = i_src1_rd;
         wr_data_s = i_src1_data;
      end else begin
         wr_addr_s = i_src0_rd;
         wr_data_s = i_src0_data;
      end
   end

   assign o_src0_ready = gnt_s[0];
   assign o_src1_ready = gnt_s[1];
   assign o_wr_addr    = wr_addr_s;
   assign o_wr_data    = wr_data_s;
   assign o_wr_en      = (gnt_s != 2'b00) & ~is_zero_reg(wr_addr_s);

   // Clear vector from the accepted src1 write-back; x0 is never tracked
   always_comb begin
      clr_vec_s = {NREG{1'b0}};
      for (int r = 1; r < NREG; r++) begin
         clr_vec_s[r] = gnt_s[1] & (i_src1_rd == ADDR_W'(r));
      end
      eff_s = busy_r & ~clr_vec_s;
   end

   // A completing write-back is bypassed, so only effective busy stalls
   always_comb begin
      if (!rst_n) begin
         stall_s = 1'b1;
      end else begin
         stall_s = i_issue_valid &
                   (eff_s[i_issue_rs1] | eff_s[i_issue_rs2] |
                    (~is_zero_reg(i_issue_rd) & eff_s[i_issue_rd]));
      end
   end

   assign issue_set_s   = i_issue_valid & ~stall_s & i_issue_multi & ~is_zero_reg(i_issue_rd);
   assign o_issue_stall = stall_s;

   // Set vector from an issued multi-cycle instruction
   always_comb begin
      set_vec_s = {NREG{1'b0}};
      for (int r = 1; r < NREG; r++) begin
         set_vec_s[r] = issue_set_s & (i_issue_rd == ADDR_W'(r));
      end
   end

   // Scoreboard register; the set is applied after the clear so it wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_r <= {NREG{1'b0}};
      else        busy_r <= (busy_r & ~clr_vec_s) | set_vec_s;
   end

   // Sticky flag for a src1 write-back that nobody was waiting for
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wb_err_r <= 1'b0;
      else if (gnt_s[1] & ~is_zero_reg(i_src1_rd) & ~busy_r[i_src1_rd])
         wb_err_r <= 1'b1;
      else
         wb_err_r <= wb_err_r;
   end

   assign o_wb_err = wb_err_r;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: directed scenarios plus a randomized
// run against a behavioural model of arbitration and the scoreboard.
module tb_rf_wb_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s0_valid = 1'b0, s1_valid = 1'b0;
   logic [4:0]  s0_rd = 5'd0, s1_rd = 5'd0;
   logic [31:0] s0_data = 32'd0, s1_data = 32'd0;
   logic        s0_ready, s1_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        is_valid = 1'b0, is_multi = 1'b0;
   logic [4:0]  is_rs1 = 5'd0, is_rs2 = 5'd0, is_rd = 5'd0;
   logic        stall, wb_err;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   bit          m_rr;
   bit [31:0]   m_busy;
   bit          m_err;
   bit          e_g0, e_g1, e_wen, e_stall;
   logic [4:0]  e_addr;
   logic [31:0] e_data;
   int          clr_reg;

   always #5 clk = ~clk;

   rf_wb_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_src0_valid (s0_valid),
      .i_src0_rd    (s0_rd),
      .i_src0_data  (s0_data),
      .o_src0_ready (s0_ready),
      .i_src1_valid (s1_valid),
      .i_src1_rd    (s1_rd),
      .i_src1_data  (s1_data),
      .o_src1_ready (s1_ready),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr),
      .o_wr_data    (wr_data),
      .i_issue_valid(is_valid),
      .i_issue_rs1  (is_rs1),
      .i_issue_rs2  (is_rs2),
      .i_issue_rd   (is_rd),
      .i_issue_multi(is_multi),
      .o_issue_stall(stall),
      .o_wb_err     (wb_err)
   );

   function automatic bit m_eff(input int r);
      return (r != 0) && m_busy[r] && (r != clr_reg);
   endfunction

   task automatic model_eval();
      if (s0_valid && s1_valid) begin
         e_g0 = (m_rr == 1'b0);
         e_g1 = (m_rr == 1'b1);
      end else begin
         e_g0 = s0_valid;
         e_g1 = s1_valid;
      end
      e_addr  = e_g1 ? s1_rd : s0_rd;
      e_data  = e_g1 ? s1_data : s0_data;
      e_wen   = (e_g0 || e_g1) && (e_addr != 5'd0);
      clr_reg = (e_g1 && s1_rd != 5'd0) ? int'(s1_rd) : 0;
      e_stall = is_valid && (m_eff(int'(is_rs1)) || m_eff(int'(is_rs2)) ||
                             (is_rd != 5'd0 && m_eff(int'(is_rd))));
   endtask

   task automatic model_commit();
      if (e_g1 && s1_rd != 5'd0 && !m_busy[s1_rd]) m_err = 1'b1;
      if (clr_reg != 0) m_busy[clr_reg] = 1'b0;
      if (is_valid && !e_stall && is_multi && is_rd != 5'd0) m_busy[is_rd] = 1'b1;
      if (e_g0)      m_rr = 1'b1;
      else if (e_g1) m_rr = 1'b0;
   endtask

   task automatic idle_inputs();
      s0_valid = 1'b0; s1_valid = 1'b0; is_valid = 1'b0; is_multi = 1'b0;
      s0_rd = 5'd0; s1_rd = 5'd0; is_rs1 = 5'd0; is_rs2 = 5'd0; is_rd = 5'd0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_rr = 1'b0; m_busy = 32'd0; m_err = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s0_valid = 1'b1; s0_rd = 5'd3; s1_valid = 1'b1; s1_rd = 5'd4; is_valid = 1'b1;
      #2;
      n_checks++; if (s0_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready0 got=%b exp=0", s0_ready); end
      n_checks++; if (s1_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready1 got=%b exp=0", s1_ready); end
      n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_stall got=%b exp=1", stall); end
      n_checks++; if (wb_err !== 1'b0) begin n_errors++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
      @(negedge clk);
      rst_n = 1'b1;
      s0_valid = 1'b0; s1_valid = 1'b0;
      is_valid = 1'b1; is_rs1 = 5'd1; is_rs2 = 5'd2; is_rd = 5'd3;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_release_stall got=%b exp=0", stall); end
      idle_inputs();
   endtask

   task automatic test_src0_single();
      apply_reset();
      @(negedge clk);
      s0_valid = 1'b1; s0_rd = 5'd5; s0_data = 32'hDEADBEEF;
      #2;
      n_checks++; if (s0_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready0 got=%b exp=1", s0_ready); end
      n_checks++; if (s1_ready !== 1'b0) begin n_errors++; $display("FAIL single_ready1 got=%b exp=0", s1_ready); end
      n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
      n_checks++; if (wr_addr !== 5'd5) begin n_errors++; $display("FAIL single_wr_addr got=%0d exp=5", wr_addr); end
      n_checks++; if (wr_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_wr_data got=%h exp=deadbeef", wr_data); end
      // pointer must now favour src1
      @(negedge clk);
      s0_rd = 5'd2; s0_data = 32'h1; s1_valid = 1'b1; s1_rd = 5'd8; s1_data = 32'h2;
      #2;
      n_checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin n_errors++; $display("FAIL single_rr got=%b%b exp=10", s1_ready, s0_ready); end
      n_checks++; if (wr_addr !== 5'd8) begin n_errors++; $display("FAIL single_rr_addr got=%0d exp=8", wr_addr); end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [31:0] k0, k1;
      bit          exp1;
      apply_reset();
      k0 = 32'd0; k1 = 32'd0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'hA000_0000 + k0;
         s1_valid = 1'b1; s1_rd = 5'd7; s1_data = 32'hB000_0000 + k1;
         #2;
         exp1 = (c % 2 == 1);
         n_checks++; if (s1_ready !== exp1 || s0_ready !== !exp1) begin n_errors++; $display("FAIL b2b_grant cyc=%0d got=%b%b exp=%b%b", c, s1_ready, s0_ready, exp1, !exp1); end
         n_checks++; if (wr_addr !== (exp1 ? 5'd7 : 5'd3)) begin n_errors++; $display("FAIL b2b_addr cyc=%0d got=%0d", c, wr_addr); end
         n_checks++; if (wr_data !== (exp1 ? 32'hB000_0000 + k1 : 32'hA000_0000 + k0)) begin n_errors++; $display("FAIL b2b_data cyc=%0d got=%h", c, wr_data); end
         if (exp1) k1 = k1 + 32'd1;
         else      k0 = k0 + 32'd1;
      end
      idle_inputs();
   endtask

   task automatic test_raw_bypass();
      apply_reset();
      @(negedge clk);
      is_valid = 1'b1; is_multi = 1'b1; is_rd = 5'd9; is_rs1 = 5'd0; is_rs2 = 5'd0;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL raw_issue got=%b exp=0", stall); end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         is_multi = 1'b0; is_rd = 5'd0; is_rs1 = 5'd9;
         #2;
         n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL raw_stall cyc=%0d got=%b exp=1", c, stall); end
      end
      @(negedge clk);
      s1_valid = 1'b1; s1_rd = 5'd9; s1_data = 32'h0000_0099;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL raw_bypass got=%b exp=0", stall); end
      n_checks++; if (s1_ready !== 1'b1 || wr_en !== 1'b1) begin n_errors++; $display("FAIL raw_wb got=%b%b exp=11", s1_ready, wr_en); end
      @(negedge clk);
      s1_valid = 1'b0;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL raw_cleared got=%b exp=0", stall); end
      n_checks++; if (wb_err !== 1'b0) begin n_errors++; $display("FAIL raw_wb_err got=%b exp=0", wb_err); end
      idle_inputs();
   endtask

   task automatic test_set_wins();
      apply_reset();
      @(negedge clk);
      is_valid = 1'b1; is_multi = 1'b1; is_rd = 5'd12;
      @(negedge clk);
      s1_valid = 1'b1; s1_rd = 5'd12; s1_data = 32'h12;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL setwin_issue got=%b exp=0", stall); end
      @(negedge clk);
      s1_valid = 1'b0; is_multi = 1'b0; is_rd = 5'd0; is_rs2 = 5'd12;
      #2;
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL setwin_busy got=%b exp=1", stall); end
      n_checks++; if (wb_err !== 1'b0) begin n_errors++; $display("FAIL setwin_wb_err got=%b exp=0", wb_err); end
      idle_inputs();
   endtask

   task automatic test_wb_err();
      apply_reset();
      @(negedge clk);
      s1_valid = 1'b1; s1_rd = 5'd0; s1_data = 32'h5555_5555;
      #2;
      n_checks++; if (s1_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready got=%b exp=1", s1_ready); end
      n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL x0_wr_en got=%b exp=0", wr_en); end
      @(negedge clk);
      s1_rd = 5'd4; s1_data = 32'h4444_4444;
      #2;
      n_checks++; if (wb_err !== 1'b0) begin n_errors++; $display("FAIL x0_wb_err got=%b exp=0", wb_err); end
      n_checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd4) begin n_errors++; $display("FAIL err_write got=%b/%0d exp=1/4", wr_en, wr_addr); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         s1_valid = 1'b0;
         #2;
         n_checks++; if (wb_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky cyc=%0d got=%b exp=1", c, wb_err); end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      apply_reset();
      @(negedge clk);
      is_valid = 1'b1; is_multi = 1'b1; is_rd = 5'd6;
      @(negedge clk);
      is_multi = 1'b0; is_rd = 5'd0; is_rs1 = 5'd6;
      s0_valid = 1'b1; s0_rd = 5'd1; s0_data = 32'h1111;
      #2;
      n_checks++; if (stall !== 1'b1 || s0_ready !== 1'b1) begin n_errors++; $display("FAIL arst_pre got=%b%b exp=11", stall, s0_ready); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (s0_ready !== 1'b0) begin n_errors++; $display("FAIL arst_ready got=%b exp=0", s0_ready); end
      n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL arst_wr_en got=%b exp=0", wr_en); end
      n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL arst_stall got=%b exp=1", stall); end
      @(negedge clk);
      rst_n = 1'b1; s0_valid = 1'b0;
      #2;
      n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL arst_cleared got=%b exp=0", stall); end
      idle_inputs();
   endtask

   task automatic test_random();
      bit p0, p1;
      apply_reset();
      p0 = 1'b0; p1 = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1'b1; s0_rd = 5'($urandom_range(0, 7)); s0_data = $urandom;
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1'b1; s1_rd = 5'($urandom_range(0, 7)); s1_data = $urandom;
         end
         s0_valid = p0; s1_valid = p1;
         is_valid = 1'($urandom_range(0, 1));
         is_multi = 1'($urandom_range(0, 1));
         is_rs1 = 5'($urandom_range(0, 7));
         is_rs2 = 5'($urandom_range(0, 7));
         is_rd  = 5'($urandom_range(0, 7));
         #2;
         model_eval();
         n_checks++; if (s0_ready !== e_g0 || s1_ready !== e_g1) begin n_errors++; $display("FAIL rand_grant cyc=%0d got=%b%b exp=%b%b", c, s1_ready, s0_ready, e_g1, e_g0); end
         n_checks++; if (wr_en !== e_wen) begin n_errors++; $display("FAIL rand_wr_en cyc=%0d got=%b exp=%b", c, wr_en, e_wen); end
         if (e_g0 || e_g1) begin
            n_checks++; if (wr_addr !== e_addr || wr_data !== e_data) begin n_errors++; $display("FAIL rand_wr cyc=%0d got=%0d/%h exp=%0d/%h", c, wr_addr, wr_data, e_addr, e_data); end
         end
         n_checks++; if (stall !== e_stall) begin n_errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, stall, e_stall); end
         n_checks++; if (wb_err !== m_err) begin n_errors++; $display("FAIL rand_wb_err cyc=%0d got=%b exp=%b", c, wb_err, m_err); end
         if (e_g0) p0 = 1'b0;
         if (e_g1) p1 = 1'b0;
         model_commit();
      end
      idle_inputs();
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_src0_single();
      test_back_to_back();
      test_raw_bypass();
      test_set_wins();
      test_wb_err();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-back scheduler and hazard scoreboard in front of the 32x32 register file (x0 hardwired zero, 2R/1W, same-cycle write-to-read bypass).
- Shares the single register-file write port between two write-back sources using round-robin arbitration with a valid/ready handshake.
- Tracks registers with a pending write and stalls issue on RAW/WAW hazards.
- Sits between the decode/issue stage, the execution units (src0 = ALU, src1 = load/multi-cycle unit) and the register file.

Parameters:
- ADDR_W, 5, register address width (32 registers; x0 never tracked).
- DATA_W, 32, write data width.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_src0_valid  in  1  src0 write-back request.
- i_src0_rd  in  ADDR_W  src0 destination register.
- i_src0_data  in  DATA_W  src0 write data.
- o_src0_ready  out  1  src0 granted this cycle.
- i_src1_valid / i_src1_rd / i_src1_data / o_src1_ready  same as src0, for src1.
- o_wr_en  out  1  register-file write enable.
- o_wr_addr  out  ADDR_W  register-file write address.
- o_wr_data  out  DATA_W  register-file write data.
- i_issue_valid  in  1  decode presents an instruction.
- i_issue_rs1  in  ADDR_W  source register 1.
- i_issue_rs2  in  ADDR_W  source register 2.
- i_issue_rd  in  ADDR_W  destination register; 0 means no write.
- i_issue_multi  in  1  instruction writes back via src1 (multi-cycle); if 0, no scoreboard entry is made.
- o_issue_stall  out  1  hold the instruction in decode.
- o_wb_err  out  1  sticky error: accepted write-back to a non-busy register.

Behaviour:

Reset:
- While rst_n is low: rr pointer = 0 (src0 preferred), busy[31:1] = 0, o_wb_err = 0.
- All combinational outputs are forced as follows: o_src*_ready = 0, o_wr_en = 0, o_issue_stall = 1.
- Asserting rst_n low mid-operation discards all pending scoreboard entries; producers are reset on the same rst_n.

Arbitration (combinational grant, zero latency):
- Only one valid: grant it.
- Both valid: grant the source selected by rr.
- Neither valid: no grant, o_wr_en = 0.
- o_srcN_ready = grantN. Handshake completes when valid & ready at posedge.
- Sources must hold valid, rd and data stable until ready.
- o_wr_addr / o_wr_data = granted source's fields; o_wr_en = grant & (rd != 0).
- A grant with rd = 0 still completes the handshake; no write and no scoreboard effect.
- rr update at posedge on any grant: rr <= index of the source not granted. No grant: rr holds.

Scoreboard (busy[r], r = 1..31):
- set_r = i_issue_valid & ~o_issue_stall & i_issue_multi & (i_issue_rd == r).
- clr_r = accepted src1 write-back to r.
- An accepted src0 write-back never touches busy.
- Same register set and cleared in the same cycle: set wins (busy stays 1).
- Effective busy: eff[r] = busy[r] & ~clr_r. A completing write-back is visible through the register-file bypass, so it does not stall.
- o_issue_stall = i_issue_valid & (eff[rs1] | eff[rs2] | (rd != 0 & eff[rd])). x0 is never busy.
- Accepted src1 write-back with rd != 0 and busy[rd] = 0: o_wb_err <= 1, held until reset; the write itself still occurs.

Timing:
- No pipeline registers on the data path; write-back reaches o_wr_* in the same cycle.
- Scoreboard set/clear takes effect the cycle after the posedge.

Decomposition:
- Shared CPU package holds REG_ADDR_W = 5, XLEN = 32 and the constant REG_ZERO = 5'd0 (also used by the register file and decode).
- One natural sub-module, rr_arb2: 2-way round-robin arbiter containing the rr flop, inputs req[1:0], outputs gnt[1:0].
- The scoreboard stays in the top module.

Test Plan:
- Reset, then src0 valid rd = 5, data = 0xDEADBEEF, src1 idle -> same cycle: o_src0_ready = 1, o_wr_en = 1, o_wr_addr = 5, o_wr_data = 0xDEADBEEF; rr = 1 after the edge.
- Both sources valid for 4 cycles with distinct rd (3, 7) -> grants alternate src0, src1, src0, src1; the loser's fields are held and written when granted.
- Issue multi rd = 9, then the next instruction reads rs1 = 9 -> stall = 1 until the src1 write-back to 9 is presented. In that cycle stall = 0 (bypass) and busy[9] = 0 afterwards.
- Same cycle: src1 write-back to 12 (busy) and a non-stalled issue multi rd = 12 -> busy[12] = 1 after the edge.
- src1 write-back rd = 0 -> ready = 1, o_wr_en = 0. src1 write-back to non-busy rd = 4 -> o_wr_en = 1, o_wb_err = 1 and stays set.
- busy[6] = 1, then rst_n pulsed low asynchronously mid-cycle -> outputs immediately ready = 0, wr_en = 0, stall = 1. After release: busy[6] = 0, issue rs1 = 6 -> stall = 0.
